// File: rtl/uparc_muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; one shift-add or restoring
// step per cycle, then a sign-fix cycle that commits the result.
module uparc_muldiv_seq (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_mem_stall,
    input  logic        i_fetch_stall,
    input  logic        i_wait_stall,
    input  logic        i_nullify,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic        o_exec_stall,
    output logic        o_busy,
    output logic [31:0] o_rd_val,
    output logic        o_rd_valid
);
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rd_val_q, rd_val_d;
    logic        rd_valid_q, rd_valid_d;

    logic        op_active, core_stall, capture, start_ok;
    logic        is_signed, rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum, rem_shift, div_diff;
    logic [63:0] prod_fix;

    // Out-of-range opcodes behave exactly like NONE.
    assign op_active  = (i_op != OP_NONE) && (i_op <= OP_MTLO);
    assign core_stall = i_mem_stall | i_fetch_stall | i_wait_stall | o_exec_stall;
    assign capture    = ~core_stall;
    assign start_ok   = capture & ~i_nullify;

    assign is_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign rs_neg    = is_signed & i_rs_val[31];
    assign rt_neg    = is_signed & i_rt_val[31];
    assign rs_mag    = rs_neg ? (32'd0 - i_rs_val) : i_rs_val;
    assign rt_mag    = rt_neg ? (32'd0 - i_rt_val) : i_rt_val;

    // Shift-add: add multiplicand to the upper half when the LSB is set, shift right.
    assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};
    // Restoring step: remainder:quotient shifted left, trial subtract of the divisor.
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = rem_shift - {1'b0, b_q};
    assign prod_fix  = neg_q ? (64'd0 - acc_q) : acc_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            b_q        <= 32'd0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            is_div_q   <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            rd_val_q   <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            is_div_q   <= is_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_val_q   <= rd_val_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    case (i_op)
                        OP_MULT, OP_MULTU: state_d = ST_MUL;
                        OP_DIV, OP_DIVU:   state_d = (i_rt_val == 32'd0) ? ST_FIX : ST_DIV;
                        default:           state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MUL, ST_DIV: if (cnt_q == 5'd0) state_d = ST_FIX;
            ST_FIX:         state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        is_div_d   = is_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_val_d   = rd_val_q;
        rd_valid_d = rd_valid_q;

        // Ops that start or touch HI/LO only reach here with the unit idle.
        if (capture) begin
            if (i_nullify || !op_active) begin
                rd_valid_d = 1'b0;
            end else begin
                case (i_op)
                    OP_MULT, OP_MULTU: begin
                        acc_d     = {32'd0, rt_mag};
                        b_d       = rs_mag;
                        neg_d     = rs_neg ^ rt_neg;
                        rem_neg_d = 1'b0;
                        is_div_d  = 1'b0;
                        cnt_d     = 5'd31;
                    end
                    OP_DIV, OP_DIVU: begin
                        is_div_d = 1'b1;
                        cnt_d    = 5'd31;
                        b_d      = rt_mag;
                        if (i_rt_val == 32'd0) begin
                            acc_d     = {i_rs_val, 32'hFFFF_FFFF};
                            neg_d     = 1'b0;
                            rem_neg_d = 1'b0;
                        end else begin
                            acc_d     = {32'd0, rs_mag};
                            neg_d     = rs_neg ^ rt_neg;
                            rem_neg_d = rs_neg;
                        end
                    end
                    OP_MFHI: begin
                        rd_val_d   = hi_q;
                        rd_valid_d = 1'b1;
                    end
                    OP_MFLO: begin
                        rd_val_d   = lo_q;
                        rd_valid_d = 1'b1;
                    end
                    OP_MTHI: hi_d = i_rs_val;
                    OP_MTLO: lo_d = i_rs_val;
                    default: rd_valid_d = 1'b0;
                endcase
            end
        end

        case (state_q)
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q - 5'd1;
            end
            ST_DIV: begin
                if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                else               acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
                cnt_d = cnt_q - 5'd1;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                    hi_d = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                end else begin
                    lo_d = prod_fix[31:0];
                    hi_d = prod_fix[63:32];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy       = (state_q != ST_IDLE);
        o_exec_stall = op_active && (state_q != ST_IDLE);
        o_rd_val     = rd_val_q;
        o_rd_valid   = rd_valid_q;
    end

endmodule

// File: tb/tb_uparc_muldiv_seq.sv
// Directed bench for uparc_muldiv_seq: a table of multiply/divide vectors plus
// hand-written sequences for stalls, nullify, held MF results and reset abort.
module tb_uparc_muldiv_seq;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_mem_stall, i_fetch_stall, i_wait_stall, i_nullify;
    logic [3:0]  i_op;
    logic [31:0] i_rs_val, i_rt_val;
    logic        o_exec_stall, o_busy, o_rd_valid;
    logic [31:0] o_rd_val;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    uparc_muldiv_seq dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_mem_stall  (i_mem_stall),
        .i_fetch_stall(i_fetch_stall),
        .i_wait_stall (i_wait_stall),
        .i_nullify    (i_nullify),
        .i_op         (i_op),
        .i_rs_val     (i_rs_val),
        .i_rt_val     (i_rt_val),
        .o_exec_stall (o_exec_stall),
        .o_busy       (o_busy),
        .o_rd_val     (o_rd_val),
        .o_rd_valid   (o_rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Presents an op for one capture edge, then returns the bus to NONE.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic nul);
        i_op = op; i_rs_val = rs; i_rt_val = rt; i_nullify = nul;
        @(posedge clk); #1;
        i_op = OP_NONE; i_nullify = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] op, output logic [31:0] v, output logic vld);
        i_op = op;
        @(posedge clk); #1;
        i_op = OP_NONE;
        @(negedge clk);
        v = o_rd_val; vld = o_rd_valid;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (o_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        vld;
        int          n;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA, 33};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 33};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{OP_DIVU,  32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF, 1};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 33};
        vecs[5] = '{OP_DIVU,  32'd100,       32'd7,          32'd2,         32'd14,        33};
        vecs[6] = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 33};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 33};
        vecs[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
        vecs[9] = '{OP_MULTU, 32'd0,         32'h1234_5678,  32'd0,         32'd0,         33};

        nrst = 1'b0; i_mem_stall = 1'b0; i_fetch_stall = 1'b0; i_wait_stall = 1'b0;
        i_nullify = 1'b0; i_op = OP_NONE; i_rs_val = '0; i_rt_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_rd_valid", o_rd_valid, 0);
        chk("reset_rd_val", o_rd_val, 0);
        chk("reset_exec_stall", o_exec_stall, 0);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0);
            count_busy(n);
            chk($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cyc);
            read_reg(OP_MFHI, v, vld);
            chk($sformatf("vec%0d_hi_valid", i), vld, 1);
            chk($sformatf("vec%0d_hi", i), v, vecs[i].hi);
            read_reg(OP_MFLO, v, vld);
            chk($sformatf("vec%0d_lo", i), v, vecs[i].lo);
            $display("txn vec%0d op=%0d rs=%h rt=%h busy=%0d lo=%h", i, vecs[i].op,
                     vecs[i].rs, vecs[i].rt, n, v);
        end

        // MULT followed immediately by MFLO: MFLO stalls until idle, captured once.
        i_op = OP_MULT; i_rs_val = 32'd5; i_rt_val = 32'd6;
        @(posedge clk); #1;
        i_op = OP_MFLO;
        n = 0;
        @(negedge clk);
        while (o_exec_stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mflo_stall_cycles", n, 33);
        @(posedge clk); #1;
        i_op = OP_NONE;
        @(negedge clk);
        chk("mflo_after_stall_valid", o_rd_valid, 1);
        chk("mflo_after_stall_val", o_rd_val, 32'd30);
        @(negedge clk);
        chk("mflo_once_busy", o_busy, 0);
        chk("mflo_once_valid_cleared", o_rd_valid, 0);
        $display("txn mult_then_mflo stall=%0d", n);

        // MTHI then MFHI, result held across a memory stall.
        issue(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        i_op = OP_MFHI;
        #1;
        chk("mfhi_no_stall", o_exec_stall, 0);
        @(posedge clk); #1;
        i_op = OP_NONE; i_mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", k), o_rd_valid, 1);
            chk($sformatf("hold%0d_val", k), o_rd_val, 32'h1234_5678);
        end
        i_mem_stall = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_release_valid", o_rd_valid, 0);
        $display("txn mthi_mfhi_hold val=%h", o_rd_val);

        // Nullified MULT: no busy, HI/LO unchanged, valid cleared.
        read_reg(OP_MFLO, v, vld);
        chk("pre_nullify_lo", v, 32'd30);
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        chk("nullify_busy", o_busy, 0);
        chk("nullify_valid_cleared", o_rd_valid, 0);
        read_reg(OP_MFHI, v, vld);
        chk("nullify_hi_kept", v, 32'h1234_5678);
        read_reg(OP_MFLO, v, vld);
        chk("nullify_lo_kept", v, 32'd30);
        $display("txn nullified_mult hi_kept lo=%h", v);

        // Reset during iteration 10 of a DIV aborts it and clears everything.
        i_op = OP_MFHI;
        @(posedge clk); #1;
        i_op = OP_DIV; i_rs_val = 32'd100; i_rt_val = 32'd7;
        @(posedge clk); #1;
        i_op = OP_MFLO;
        repeat (10) @(negedge clk);
        chk("mid_div_busy", o_busy, 1);
        chk("mid_div_exec_stall", o_exec_stall, 1);
        chk("mid_div_valid_held", o_rd_valid, 1);
        chk("mid_div_val_held", o_rd_val, 32'h1234_5678);
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_exec_stall", o_exec_stall, 0);
        chk("abort_valid", o_rd_valid, 0);
        chk("abort_val", o_rd_val, 0);
        i_op = OP_NONE;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        i_op = OP_MFLO;
        #1;
        chk("post_reset_no_stall", o_exec_stall, 0);
        read_reg(OP_MFLO, v, vld);
        chk("post_reset_lo_valid", vld, 1);
        chk("post_reset_lo", v, 0);
        read_reg(OP_MFHI, v, vld);
        chk("post_reset_hi", v, 0);
        $display("txn reset_mid_div hi=%h", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uparc_muldiv_seq.md
Name: uparc_muldiv_seq

Overview:
Iterative integer multiply/divide sequencer that owns the HI/LO registers and feeds the execute stage's imuldiv result inputs. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations issued alongside execute-stage capture. It runs a 32-step shift-add or restoring-divide loop and raises the execute stall while a dependent op must wait. It sits beside the execute stage: `o_rd_val`/`o_rd_valid` drive the imuldiv result inputs, and `o_exec_stall` drives the execute-stall input.

Parameters:
None. Widths are fixed by `UPARC_REG_WIDTH (32).

Ports:
clk  in  1  core clock
nrst  in  1  asynchronous active-low reset
i_mem_stall  in  1  memory stage stall
i_fetch_stall  in  1  fetch stall
i_wait_stall  in  1  wait stall
i_nullify  in  1  drop the op being captured
i_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; other codes are treated as NONE
i_rs_val  in  32  rs operand (multiplicand/dividend, MT source)
i_rt_val  in  32  rt operand (multiplier/divisor)
o_exec_stall  out  1  stall request to the pipeline
o_busy  out  1  iteration in progress
o_rd_val  out  32  HI or LO value for a captured MF op
o_rd_valid  out  1  o_rd_val is valid for the op now in execute

Behaviour:
- Reset (async, nrst=0): HI=LO=0, state IDLE, counter=0, o_rd_val=0, o_rd_valid=0, o_busy=0. A reset during an operation aborts it; no partial HI/LO update.
- core_stall = i_mem_stall | i_fetch_stall | i_wait_stall | o_exec_stall. A capture edge is a posedge with core_stall=0.
- o_exec_stall (combinational) = (i_op != NONE) & (state != IDLE). While it is asserted the op is not captured; it is retried every cycle.
- Capture with i_nullify=1: op dropped, o_rd_valid cleared.
- Capture with i_nullify=0, by op:
  - MULT/MULTU/DIV/DIVU: latch |rs| and |rt| (raw values for the unsigned ops), record the result signs, counter=31, go to MUL or DIV.
  - MTHI/MTLO: HI or LO <= i_rs_val at that edge.
  - MFHI/MFLO: o_rd_val <= HI or LO, o_rd_valid <= 1.
  - NONE: o_rd_valid <= 0.
- o_rd_val and o_rd_valid hold while core_stall=1, because execute holds its instruction.
- FSM: IDLE -> MUL|DIV -> FIX -> IDLE.
  - MUL: one shift-add step per cycle into a 64-bit accumulator. It runs for 32 cycles (counter 31 down to 0) and never waits on core_stall.
  - DIV: one restoring step per cycle over 32 cycles, building quotient and remainder.
  - FIX: apply sign correction and write HI/LO. MUL: HI:LO = product, negated if the operand signs differ (signed only). DIV: LO = quotient, negated if signs differ; HI = remainder, taking the sign of the dividend.
  - Divide by zero (rt=0, either signedness): skip the iterations and go straight to FIX with LO=0xFFFFFFFF, HI=rs.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no trap.
- o_busy = (state != IDLE). From the capture edge, a MUL/DIV occupies 33 cycles (32 iterations + FIX). HI/LO are updated at the FIX edge.
- An MF op waiting behind a busy unit is captured on the first clock edge after the unit returns to IDLE. o_rd_valid=1 in the following cycle.
- i_nullify after capture does not abort a running operation.

Test Plan:
- MULTU rs=0xFFFFFFFE, rt=3 -> o_busy high for 33 cycles, then HI=0x00000002, LO=0xFFFFFFFA. MULT with the same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=0 -> LO=0xFFFFFFFF, HI=7 one cycle after FIX, with no iterations.
- MULT then MFLO on the next cycle -> o_exec_stall=1 until IDLE, then o_rd_valid=1 with o_rd_val=LO. The MFLO is captured exactly once.
- MTHI 0x12345678, then MFHI -> o_rd_val=0x12345678, no stall. Hold i_mem_stall=1 for 3 cycles -> o_rd_valid and o_rd_val stay stable.
- MULT presented with i_nullify=1 -> HI/LO unchanged, o_busy stays 0. DIV signed 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Assert nrst=0 at iteration 10 of a DIV -> all outputs 0 immediately, HI/LO=0. After release, a MFLO returns 0 with no stall.
